// File: rtl/light_dance_rx_if.sv
// Word stream in, recovered bit / error status out, for the light-dance receiver.
// No timing of its own: a bundle of signals between driver and receiver.
// No backpressure: the receiver accepts one word on every cycle rx_valid is high.
interface light_dance_rx_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        clear;
  logic        dout;
  logic        dout_valid;
  logic        err;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  modport master (
    output rx_data, rx_valid, clear,
    input  dout, dout_valid, err, err_cnt, state
  );

  modport slave (
    input  rx_data, rx_valid, clear,
    output dout, dout_valid, err, err_cnt, state
  );
endinterface

// File: rtl/light_dance_rx.sv
// Light-dance receiver: locks onto a generator state-word stream and recovers its serial input bit.
// Latency: all outputs registered, one clock after the sampling edge.
// No backpressure: one word per cycle is accepted indefinitely, there is no ready signal.
module light_dance_rx #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             arst,
  light_dance_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Low 7 bits of the generator step with a zero input bit. The MSB of the
  // next word is the only bit that depends on the input, so it is never predicted.
  function automatic logic [6:0] f_pred7(input logic [7:0] s);
    f_pred7 = {s[7], s[0] ^ s[6], s[0] ^ s[5], s[4], s[3], s[0] ^ s[2], s[0] ^ s[1]};
  endfunction

  state_t      r_state;
  logic [3:0]  r_good;
  logic [3:0]  r_bad;
  logic [7:0]  r_p;
  logic        r_dout;
  logic        r_dout_valid;
  logic        r_err;
  logic [15:0] r_err_cnt;

  logic [6:0]  w_pred;
  logic        w_match;
  logic        w_bit;
  logic [3:0]  w_good_nxt;
  logic [3:0]  w_bad_nxt;

  assign w_pred     = f_pred7(r_p);
  assign w_match    = (bus.rx_data[6:0] == w_pred);
  assign w_bit      = bus.rx_data[7] ^ r_p[0];
  assign w_good_nxt = r_good + 4'd1;
  assign w_bad_nxt  = r_bad + 4'd1;

  // Lock state machine, word history and registered outputs in one place.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state      <= ST_IDLE;
      r_good       <= 4'd0;
      r_bad        <= 4'd0;
      r_p          <= 8'h00;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= 16'h0000;
    end else begin
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      if (bus.clear) begin
        // Clear wins over a word arriving in the same cycle; that word is dropped.
        r_state   <= ST_IDLE;
        r_good    <= 4'd0;
        r_bad     <= 4'd0;
        r_dout    <= 1'b0;
        r_err_cnt <= 16'h0000;
      end else if (bus.rx_valid) begin
        r_p <= bus.rx_data;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_HUNT;
            r_good  <= 4'd0;
          end
          ST_HUNT: begin
            if (w_match) begin
              r_good <= w_good_nxt;
              if (w_good_nxt == 4'(LOCK_CNT)) begin
                r_state <= ST_LOCKED;
                r_bad   <= 4'd0;
              end
            end else begin
              r_good <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_dout       <= w_bit;
              r_dout_valid <= 1'b1;
              r_bad        <= 4'd0;
            end else begin
              r_err <= 1'b1;
              if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
              end
              r_bad <= w_bad_nxt;
              if (w_bad_nxt == 4'(UNLOCK_CNT)) begin
                r_state <= ST_HUNT;
                r_good  <= 4'd0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.err        = r_err;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.state      = r_state;

endmodule
